imem_dmem_arbiter: RTL and testbench
====================================

// Module: imem_dmem_arbiter
// PURPOSE
//   Shares one single-port memory between the fetch stage (instruction reads) and the
//   MEM stage (data loads/stores) in the unified-memory build of the 5-stage pipeline.
//   Serialises accesses through a small FSM and generates the per-requester stall lines
//   that feed the pipeline freeze logic. Drives a req/ack memory interface with a timeout.
// PARAMETERS
//   ADDR_W      32   address width
//   DATA_W      32   data width
//   TIMEOUT     255  max cycles waiting for ram_ack before abort; 0 = never time out
//   STARVE_MAX  4    consecutive MEM grants after which a pending IF wins (fairness macro only)
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous, active-high reset
//   if_req     in   1       fetch request; held with if_addr until if_valid
//   if_addr    in   ADDR_W  fetch address (PC)
//   if_rdata   out  DATA_W  fetched instruction, valid when if_valid
//   if_valid   out  1       one-cycle completion pulse for fetch
//   if_stall   out  1       if_req & ~if_valid (combinational)
//   mem_req    in   1       data request; held with mem_we/addr/wdata until mem_valid
//   mem_we     in   1       1 = store, 0 = load
//   mem_addr   in   ADDR_W  data address
//   mem_wdata  in   DATA_W  store data
//   mem_rdata  out  DATA_W  load data, valid when mem_valid
//   mem_valid  out  1       one-cycle completion pulse for data access
//   mem_stall  out  1       mem_req & ~mem_valid (combinational)
//   ram_req    out  1       memory request, held until ram_ack or abort
//   ram_we     out  1       memory write enable
//   ram_addr   out  ADDR_W  memory address
//   ram_wdata  out  DATA_W  memory write data
//   ram_ack    in   1       memory completion; ram_rdata valid same cycle
//   ram_rdata  in   DATA_W  memory read data
//   err        out  1       sticky timeout flag, cleared only by rst
// BEHAVIOUR
//   - Reset: state IDLE; ram_req/ram_we/if_valid/mem_valid/err = 0; ram_addr/ram_wdata/
//     if_rdata/mem_rdata = 0; timeout and starve counters = 0. An in-flight access is
//     dropped on the reset edge (ram_req low next cycle); late ram_ack ignored in IDLE.
//   - FSM IDLE -> GRANT_MEM if mem_req; else -> GRANT_IF if if_req; else stay.
//     MEM has fixed priority (older instruction). Both pending: MEM granted first.
//   - On grant edge: ram_req=1, ram_addr/ram_we/ram_wdata registered from winner
//     (IF: ram_we=0, ram_wdata=0). Outputs to RAM are registered, stable while granted.
//   - GRANT_x: on ram_ack -> latch ram_rdata into x_rdata (stores: mem_rdata unchanged),
//     pulse x_valid for exactly 1 cycle, ram_req=0, return to IDLE. Minimum access latency:
//     req seen cycle 0, ram_req cycle 1, ack earliest cycle 1, x_valid cycle 2.
//     One idle cycle between back-to-back accesses (max throughput 1 per 2 cycles).
//   - Timeout: counter runs while granted; when it reaches TIMEOUT without ack -> abort,
//     err<=1, x_rdata<=0, pulse x_valid, IDLE. Counter cleared on every grant.
//   - Requests are not cancellable: dropping x_req mid-grant still completes the access
//     and pulses x_valid. Requester inputs are sampled only on the grant edge.
//   - ram_ack while IDLE: ignored. x_valid never asserted for a non-granted side.
// CONFIGURATION
//   MEM_ARB_FAIR_EN defined: count consecutive MEM grants issued while if_req was pending;
//     when count == STARVE_MAX and both request, IF is granted; count clears on any IF
//     grant or when if_req is low at a grant decision.
//   MEM_ARB_FAIR_EN undefined: strict MEM-over-IF priority; STARVE_MAX unused, no counter.
// TESTING
//   1. if_req=1, if_addr=0x10, ram acks 1 cycle after ram_req with 0x8C010004 ->
//      ram_addr=0x10, ram_we=0, if_valid pulses once with if_rdata=0x8C010004; if_stall low then.
//   2. mem_req=1, mem_we=1, addr=0x200, wdata=0xDEADBEEF, ack after 3 cycles ->
//      ram_we=1, ram_wdata=0xDEADBEEF, mem_stall high 4 cycles, mem_valid one pulse.
//   3. if_req and mem_req same cycle (mem load 0x40 -> 0x55, fetch 0x14 -> 0x66) ->
//      MEM served first, then IF after one idle cycle; if_stall high until its valid.
//   4. TIMEOUT=8, ram_ack never asserted on fetch -> abort after 8 granted cycles,
//      if_valid pulse with if_rdata=0, err=1 and stays 1 until rst.
//   5. rst asserted 2 cycles into a granted load -> next cycle ram_req=0, state IDLE,
//      late ram_ack produces no mem_valid; all outputs at reset values.
//   6. MEM_ARB_FAIR_EN, STARVE_MAX=4, mem_req and if_req held high continuously ->
//      grant order MEM,MEM,MEM,MEM,IF,MEM...; without macro IF never granted.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
//   Shares one single-port memory between instruction fetch (IF) and data
//   access (MEM) in the unified-memory pipeline build. Accesses are
//   serialised by a three-state FSM. Each requester gets a combinational
//   stall line for the pipeline freeze logic. Memory side is req/ack with an
//   optional timeout that aborts a hung access and sets a sticky error flag.
//
// Handshake: x_req is raised with its address/data and held until x_valid.
//   Inputs are sampled only on the grant edge. x_valid is a one-cycle pulse.
//   If x_req is still high in the x_valid cycle, that is a new request.
//   ram_req is held with stable ram_we/addr/wdata until ram_ack, abort or reset.
//   ram_rdata is taken in the ram_ack cycle.
//
// Parameters: ADDR_W, DATA_W, TIMEOUT (0 = never abort), STARVE_MAX.
// Optional feature: define MEM_ARB_FAIR_EN to enable IF anti-starvation
//   (after STARVE_MAX MEM grants in a row with IF waiting, IF wins).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request and address
//   if_rdata/if_valid/if_stall    fetch response, completion pulse, stall
//   mem_req/mem_we/mem_addr/mem_wdata   data request
//   mem_rdata/mem_valid/mem_stall       data response, completion pulse, stall
//   ram_req/ram_we/ram_addr/ram_wdata   memory request (registered)
//   ram_ack/ram_rdata             memory completion and read data
//   err                           sticky timeout flag
//   dbg_state                     current FSM state (0 idle, 1 mem, 2 fetch)
module imem_dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              mem_stall,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_GRANT_MEM = 2'd1;
  localparam logic [1:0] S_GRANT_IF  = 2'd2;

  // Counter only needs to reach TIMEOUT-1; the abort fires on that cycle.
  localparam int TCW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TMO_EN = (TIMEOUT != 0);

  logic [1:0]        r_state;
  logic              r_ram_req;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_if_valid;
  logic              r_mem_valid;
  logic              r_err;
  logic [TCW-1:0]    r_tcnt;

  logic w_starved;
  logic w_grant_mem;
  logic w_grant_if;
  logic w_tmo_hit;
  logic w_granted;

`ifdef MEM_ARB_FAIR_EN
  localparam int SCW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  logic [SCW-1:0] r_starve;

  assign w_starved = (r_starve == SCW'(STARVE_MAX));

  // Counts MEM grants made while IF was waiting; saturates at STARVE_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (r_state == S_IDLE && (mem_req || if_req)) begin
      if (w_grant_if || !if_req) begin
        r_starve <= '0;
      end else if (!w_starved) begin
        r_starve <= r_starve + SCW'(1);
      end
    end
  end
`else
  assign w_starved = 1'b0;
`endif

  // MEM holds the older instruction, so it wins unless IF has starved.
  assign w_grant_mem = mem_req & ~(if_req & w_starved);
  assign w_grant_if  = if_req & ~w_grant_mem;
  assign w_tmo_hit   = TMO_EN && (r_tcnt == TCW'(TIMEOUT - 1));
  assign w_granted   = (r_state == S_GRANT_MEM) || (r_state == S_GRANT_IF);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ram_req   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_err       <= 1'b0;
      r_tcnt      <= '0;
    end else begin
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tcnt <= '0;
          if (w_grant_mem) begin
            r_state     <= S_GRANT_MEM;
            r_ram_req   <= 1'b1;
            r_ram_we    <= mem_we;
            r_ram_addr  <= mem_addr;
            r_ram_wdata <= mem_wdata;
          end else if (w_grant_if) begin
            r_state     <= S_GRANT_IF;
            r_ram_req   <= 1'b1;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= if_addr;
            r_ram_wdata <= '0;
          end
        end
        S_GRANT_MEM, S_GRANT_IF: begin
          if (ram_ack || w_tmo_hit) begin
            r_state   <= S_IDLE;
            r_ram_req <= 1'b0;
            r_ram_we  <= 1'b0;
            if (!ram_ack) begin
              r_err <= 1'b1;
            end
            if (r_state == S_GRANT_MEM) begin
              r_mem_valid <= 1'b1;
              // A completed store leaves the last load data in place.
              if (!ram_ack) begin
                r_mem_rdata <= '0;
              end else if (!r_ram_we) begin
                r_mem_rdata <= ram_rdata;
              end
            end else begin
              r_if_valid <= 1'b1;
              r_if_rdata <= ram_ack ? ram_rdata : '0;
            end
          end else begin
            r_tcnt <= r_tcnt + TCW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_ram_req <= 1'b0;
        end
      endcase
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign if_stall  = if_req & ~r_if_valid;
  assign mem_rdata = r_mem_rdata;
  assign mem_valid = r_mem_valid;
  assign mem_stall = mem_req & ~r_mem_valid;
  assign ram_req   = r_ram_req & w_granted;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
module tb_imem_dmem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 8;
  localparam int SMAX = 4;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          if_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_valid;
  logic          mem_stall;
  logic          ram_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_ack;
  logic [DW-1:0] ram_rdata;
  logic          err;
  logic [1:0]    dbg_state;

  imem_dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .mem_stall(mem_stall),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_assert = 0;
  int n_fail   = 0;
  int total_valid = 0;
  bit stray_ack = 1'b0;
  logic [32:0] exp_q[$];      // {is_mem, rdata}
  logic [64:0] exp_ram_q[$];  // {we, addr, wdata}
  logic [40:0] rsp_q[$];      // {no_ack, delay, data}

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_acc(input bit is_mem, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input bit no_ack, input logic [7:0] dly,
                            input logic [31:0] ram_d, input logic [31:0] exp_d);
    exp_ram_q.push_back({we, a, d});
    rsp_q.push_back({no_ack, dly, ram_d});
    exp_q.push_back({is_mem, exp_d});
  endtask

  // monitor: pops the expected response on every completion pulse
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (if_valid || mem_valid) begin
        total_valid++;
        chk("single_valid", {71'd0, if_valid & mem_valid}, 72'd0);
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_valid: got if_valid=%0b mem_valid=%0b expected none", if_valid, mem_valid);
        end else begin
          e = exp_q.pop_front();
          chk("valid_side", {71'd0, mem_valid}, {71'd0, e[32]});
          chk("rdata", mem_valid ? mem_rdata : if_rdata, e[31:0]);
          chk("stall_at_valid", mem_valid ? mem_stall : if_stall, 72'd0);
        end
      end
    end
  end

  // memory model: checks each request and acks after the queued delay
  initial begin : ram_model
    int cnt;
    logic [40:0] rsp;
    logic [64:0] cur;
    cnt = 0; rsp = '0; cur = '0;
    ram_ack = 1'b0;
    ram_rdata = '0;
    forever begin
      @(negedge clk);
      ram_ack = 1'b0;
      if (ram_req) begin
        if (cnt == 0) begin
          cur = {ram_we, ram_addr, ram_wdata};
          if (exp_ram_q.size() == 0 || rsp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_ram_req: got 0x%0h expected none", cur);
            rsp = {1'b1, 8'd0, 32'd0};
          end else begin
            chk("ram_req_fields", cur, exp_ram_q.pop_front());
            rsp = rsp_q.pop_front();
          end
        end else begin
          chk("ram_stable", {ram_we, ram_addr, ram_wdata}, cur);
        end
        if (!rsp[40] && cnt == int'(rsp[39:32])) begin
          ram_ack = 1'b1;
          ram_rdata = rsp[31:0];
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
        if (stray_ack) begin
          ram_ack = 1'b1;
          ram_rdata = 32'hFFFF_FFFF;
        end
      end
    end
  end

  // driver tasks
  task automatic start_if(input logic [31:0] a);
    if_req = 1'b1;
    if_addr = a;
  endtask

  task automatic start_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
    mem_req = 1'b1;
    mem_we = we;
    mem_addr = a;
    mem_wdata = d;
  endtask

  // Returns just after the negedge where the pulse is seen; counts stall samples.
  task automatic wait_valid(input bit is_mem, output int stalls);
    stalls = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (is_mem ? mem_valid : if_valid) return;
      if (is_mem ? mem_stall : if_stall) stalls++;
      @(negedge clk);
    end
    n_assert++;
    n_fail++;
    $display("FAIL wait_valid_timeout: got no valid expected valid (is_mem=%0b)", is_mem);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ram_req"},   ram_req,   0);
    chk({tag, "_ram_we"},    ram_we,    0);
    chk({tag, "_ram_addr"},  ram_addr,  0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
    chk({tag, "_if_valid"},  if_valid,  0);
    chk({tag, "_mem_valid"}, mem_valid, 0);
    chk({tag, "_if_rdata"},  if_rdata,  0);
    chk({tag, "_mem_rdata"}, mem_rdata, 0);
    chk({tag, "_err"},       err,       0);
    chk({tag, "_state"},     dbg_state, 0);
  endtask

  initial begin : stimulus
    int s;
    int base;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // fetch, ack one cycle after ram_req
    expect_acc(0, 0, 32'h10, 32'h0, 0, 8'd1, 32'h8C01_0004, 32'h8C01_0004);
    start_if(32'h10);
    wait_valid(0, s);
    if_req = 1'b0;
    chk("t1_if_stall_cycles", s, 3);
    @(negedge clk); #1;
    chk("t1_if_valid_one_pulse", if_valid, 0);

    // simultaneous requests: MEM first, then IF after one idle cycle
    expect_acc(1, 0, 32'h40, 32'h0, 0, 8'd0, 32'h55, 32'h55);
    expect_acc(0, 0, 32'h14, 32'h0, 0, 8'd0, 32'h66, 32'h66);
    start_mem(0, 32'h40, 32'h0);
    start_if(32'h14);
    wait_valid(1, s);
    mem_req = 1'b0;
    chk("t3_mem_stall_cycles", s, 2);
    chk("t3_if_stall_during_mem", if_stall, 1);
    wait_valid(0, s);
    if_req = 1'b0;
    chk("t3_if_stall_after_mem", s, 2);
    @(negedge clk);

    // store, ack on third ram_req cycle; load data is kept
    expect_acc(1, 1, 32'h200, 32'hDEAD_BEEF, 0, 8'd2, 32'hBAD0_BAD0, 32'h55);
    start_mem(1, 32'h200, 32'hDEAD_BEEF);
    wait_valid(1, s);
    mem_req = 1'b0;
    chk("t2_mem_stall_cycles", s, 4);
    @(negedge clk);

    // fetch timeout
    expect_acc(0, 0, 32'h30, 32'h0, 1, 8'd0, 32'h0, 32'h0);
    start_if(32'h30);
    wait_valid(0, s);
    if_req = 1'b0;
    chk("t4_timeout_stall_cycles", s, TMO + 1);
    chk("t4_err_set", err, 1);
    @(negedge clk);
    expect_acc(0, 0, 32'h34, 32'h0, 0, 8'd0, 32'h77, 32'h77);
    start_if(32'h34);
    wait_valid(0, s);
    if_req = 1'b0;
    chk("t4_err_sticky", err, 1);
    @(negedge clk);

    // reset in the middle of a granted load
    exp_ram_q.push_back({1'b0, 32'h80, 32'h0});
    rsp_q.push_back({1'b0, 8'd10, 32'h99});
    start_mem(0, 32'h80, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("t5_granted", ram_req, 1);
    rst = 1'b1;
    mem_req = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs("t5");
    rst = 1'b0;
    @(posedge clk); #1;
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("t5_idle_after_stray_ack", ram_req, 0);
    chk("t5_no_mem_valid", mem_valid, 0);

    // both requests held continuously
`ifdef MEM_ARB_FAIR_EN
    for (int i = 0; i < 4; i++)
      expect_acc(1, 0, 32'h300, 32'h0, 0, 8'd0, 32'h1000 + i, 32'h1000 + i);
    expect_acc(0, 0, 32'h20, 32'h0, 0, 8'd0, 32'h2000, 32'h2000);
    expect_acc(1, 0, 32'h300, 32'h0, 0, 8'd0, 32'h1004, 32'h1004);
`else
    for (int i = 0; i < 6; i++)
      expect_acc(1, 0, 32'h300, 32'h0, 0, 8'd0, 32'h1000 + i, 32'h1000 + i);
`endif
    base = total_valid;
    start_mem(0, 32'h300, 32'h0);
    start_if(32'h20);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (total_valid >= base + 6) break;
    end
    mem_req = 1'b0;
    if_req = 1'b0;
    chk("t6_valid_count", total_valid - base, 6);
    repeat (4) @(negedge clk);
    #1;
    chk("t6_responses_drained", exp_q.size(), 0);
    chk("t6_ram_reqs_drained", exp_ram_q.size(), 0);
    chk("t6_idle", dbg_state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
